// File: rtl/eq_mac_sequencer.sv
// Per-sample sequencer for the shared equalizer multiply-accumulate datapath.
// Optional feature macro: EQ_GAIN_RAMP_EN (slew-limits gain table updates per sample).
module eq_mac_sequencer #(
  parameter int          NUM_FILTERS = 4,
  parameter int          MULT_LAT    = 3,
  parameter int          ACC_LAT     = 1,
  parameter logic [15:0] UNITY_GAIN  = 16'h4000,
  parameter logic [15:0] RAMP_STEP   = 16'h0100,
  localparam int         SW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_strobe,
  input  logic          eq_bypass,
  input  logic          eq_wr,
  input  logic [3:0]    eq_wr_sel,
  input  logic [7:0]    eq_gain_lsb,
  input  logic [7:0]    eq_gain_msb,
  input  logic          overrun_clr,
  output logic [SW-1:0] filt_sel,
  output logic [15:0]   gain,
  output logic          mac_ce,
  output logic          accum_load,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  // cyc is the cycle index within a sequence: 1 in LOAD, DONE_CYC in DONE, 0 in IDLE
  localparam logic [7:0] ISSUE_END = 8'(NUM_FILTERS + 1);
  localparam logic [7:0] DONE_CYC  = 8'(NUM_FILTERS + MULT_LAT + ACC_LAT + 1);
  localparam logic [7:0] CE_LAST   = 8'(NUM_FILTERS + MULT_LAT + ACC_LAT);
  localparam logic [7:0] LOAD_HIT  = 8'(2 + MULT_LAT);

  state_t        state, state_nxt;
  logic [7:0]    cyc, cyc_nxt;
  logic          byp_q, byp_nxt;
  logic [15:0]   shadow     [NUM_FILTERS];
  logic [15:0]   active     [NUM_FILTERS];
  logic [15:0]   active_nxt [NUM_FILTERS];
  logic [SW-1:0] filt_nxt;
  logic [15:0]   gain_nxt;
  logic          mac_ce_nxt, accum_load_nxt, out_valid_nxt, busy_nxt, overrun_nxt;
  logic          wr_hit;

`ifdef EQ_GAIN_RAMP_EN
  function automatic logic [15:0] load_gain(input logic [15:0] cur, input logic [15:0] tgt);
    logic [15:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      load_gain = (diff <= RAMP_STEP) ? tgt : cur + RAMP_STEP;
    end else begin
      diff = cur - tgt;
      load_gain = (diff <= RAMP_STEP) ? tgt : cur - RAMP_STEP;
    end
  endfunction
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
`endif

  assign wr_hit = eq_wr && ({1'b0, eq_wr_sel} < 5'(NUM_FILTERS));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = sample_strobe ? LOAD : IDLE;
      LOAD:    state_nxt = ISSUE;
      ISSUE:   if (cyc == ISSUE_END) state_nxt = (CE_LAST == ISSUE_END) ? DONE : DRAIN;
               else                  state_nxt = ISSUE;
      DRAIN:   if (cyc == CE_LAST) state_nxt = DONE;
               else                state_nxt = DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cyc_nxt = (state_nxt == IDLE) ? 8'd0 : cyc + 8'd1;
  end

  // Table snapshot in LOAD; later writes only reach the shadow copy
  always_comb begin
    byp_nxt = byp_q;
    for (int i = 0; i < NUM_FILTERS; i++) active_nxt[i] = active[i];
    if (state == LOAD) begin
      byp_nxt = eq_bypass;
      for (int i = 0; i < NUM_FILTERS; i++) begin
`ifdef EQ_GAIN_RAMP_EN
        active_nxt[i] = load_gain(active[i], shadow[i]);
`else
        active_nxt[i] = shadow[i];
`endif
      end
    end else begin
      byp_nxt = byp_q;
    end
  end

  // Outputs are computed one cycle ahead and registered
  always_comb begin
    filt_nxt = filt_sel;
    gain_nxt = gain;
    case (state_nxt)
      IDLE, LOAD: begin
        filt_nxt = '0;
        gain_nxt = 16'h0000;
      end
      ISSUE: begin
        filt_nxt = SW'(cyc_nxt - 8'd2);
        gain_nxt = byp_nxt ? UNITY_GAIN : active_nxt[filt_nxt];
      end
      DRAIN, DONE: begin
        filt_nxt = filt_sel;
        gain_nxt = gain;
      end
      default: begin
        filt_nxt = '0;
        gain_nxt = 16'h0000;
      end
    endcase
    mac_ce_nxt     = (cyc_nxt >= 8'd2) && (cyc_nxt <= CE_LAST);
    accum_load_nxt = (cyc_nxt == LOAD_HIT);
    out_valid_nxt  = (state_nxt == DONE);
    busy_nxt       = (state_nxt != IDLE);
    if (sample_strobe && (state != IDLE)) overrun_nxt = 1'b1;
    else if (overrun_clr)                 overrun_nxt = 1'b0;
    else                                  overrun_nxt = overrun;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= 8'd0;
      byp_q      <= 1'b0;
      filt_sel   <= '0;
      gain       <= 16'h0000;
      mac_ce     <= 1'b0;
      accum_load <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        shadow[i] <= UNITY_GAIN;
        active[i] <= UNITY_GAIN;
      end
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      byp_q      <= byp_nxt;
      filt_sel   <= filt_nxt;
      gain       <= gain_nxt;
      mac_ce     <= mac_ce_nxt;
      accum_load <= accum_load_nxt;
      out_valid  <= out_valid_nxt;
      busy       <= busy_nxt;
      overrun    <= overrun_nxt;
      for (int i = 0; i < NUM_FILTERS; i++) active[i] <= active_nxt[i];
      if (wr_hit) shadow[eq_wr_sel[SW-1:0]] <= {eq_gain_msb, eq_gain_lsb};
    end
  end

endmodule

// File: tb/tb_eq_mac_sequencer.sv
// Directed self-checking bench for eq_mac_sequencer (default parameters).
module tb_eq_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset, sample_strobe, eq_bypass, eq_wr, overrun_clr;
  logic [3:0]  eq_wr_sel;
  logic [7:0]  eq_gain_lsb, eq_gain_msb;
  logic [1:0]  filt_sel;
  logic [15:0] gain;
  logic        mac_ce, accum_load, out_valid, busy, overrun;

  int errors = 0;
  int checks = 0;

  logic [1:0]  cap_filt [0:12];
  logic [15:0] cap_gain [0:12];
  logic        cap_ce   [0:12];
  logic        cap_al   [0:12];
  logic        cap_ov   [0:12];
  logic        cap_vld  [0:12];
  logic        cap_busy [0:12];

  eq_mac_sequencer dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .eq_bypass(eq_bypass),
    .eq_wr(eq_wr), .eq_wr_sel(eq_wr_sel), .eq_gain_lsb(eq_gain_lsb), .eq_gain_msb(eq_gain_msb),
    .overrun_clr(overrun_clr), .filt_sel(filt_sel), .gain(gain), .mac_ce(mac_ce),
    .accum_load(accum_load), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input logic [3:0] sel, input logic [15:0] val);
    eq_wr = 1'b1; eq_wr_sel = sel; eq_gain_msb = val[15:8]; eq_gain_lsb = val[7:0];
    tick();
    eq_wr = 1'b0;
  endtask

  // Strobe at cycle 0, optional write/second strobe/clear at given cycles; capture cycles 1..12
  task automatic run_seq(input int wr_cyc, input logic [3:0] sel, input logic [15:0] val,
                         input int stb2_cyc, input int clr_cyc, input logic byp);
    for (int c = 0; c < 12; c++) begin
      sample_strobe = (c == 0) || (c == stb2_cyc);
      eq_wr         = (c == wr_cyc);
      eq_wr_sel     = sel;
      eq_gain_msb   = val[15:8];
      eq_gain_lsb   = val[7:0];
      overrun_clr   = (c == clr_cyc);
      eq_bypass     = byp;
      tick();
      cap_filt[c+1] = filt_sel;  cap_gain[c+1] = gain;      cap_ce[c+1]   = mac_ce;
      cap_al[c+1]   = accum_load; cap_ov[c+1]  = overrun;   cap_vld[c+1]  = out_valid;
      cap_busy[c+1] = busy;
    end
    sample_strobe = 1'b0; eq_wr = 1'b0; overrun_clr = 1'b0; eq_bypass = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({filt_sel, gain, mac_ce, accum_load, out_valid, busy, overrun} !== 23'd0) begin
      errors++;
      $display("FAIL %s: outputs filt=%0h gain=%h ce=%b al=%b vld=%b busy=%b ov=%b, required all 0",
               tag, filt_sel, gain, mac_ce, accum_load, out_valid, busy, overrun);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_strobe = 1'b0; eq_bypass = 1'b0; eq_wr = 1'b0; overrun_clr = 1'b0;
    eq_wr_sel = 4'd0; eq_gain_lsb = 8'd0; eq_gain_msb = 8'd0;
    tick(); tick();
    check_idle_outputs("reset_state");
    reset = 1'b0;
    tick();
    check_idle_outputs("after_reset_idle");
  endtask

  task automatic test_basic();
    logic exp_ce, exp_busy;
    run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (cap_gain[c] !== 16'h4000 || cap_filt[c] !== 2'(c - 2)) begin
        errors++;
        $display("FAIL basic_issue c%0d: gain=%h filt=%0d, required gain=4000 filt=%0d",
                 c, cap_gain[c], cap_filt[c], c - 2);
      end
    end
    for (int c = 1; c <= 11; c++) begin
      exp_ce   = (c >= 2) && (c <= 8);
      exp_busy = (c >= 1) && (c <= 9);
      checks++;
      if (cap_ce[c] !== exp_ce || cap_al[c] !== (c == 5) || cap_vld[c] !== (c == 9) ||
          cap_busy[c] !== exp_busy) begin
        errors++;
        $display("FAIL basic_ctrl c%0d: ce=%b al=%b vld=%b busy=%b, required ce=%b al=%b vld=%b busy=%b",
                 c, cap_ce[c], cap_al[c], cap_vld[c], cap_busy[c], exp_ce, c == 5, c == 9, exp_busy);
      end
    end
    checks++;
    if (cap_filt[7] !== 2'd3 || cap_gain[7] !== 16'h4000) begin
      errors++;
      $display("FAIL drain_hold: filt=%0d gain=%h, required filt=3 gain=4000", cap_filt[7], cap_gain[7]);
    end
  endtask

  task automatic test_write_mid_issue();
    run_seq(3, 4'd2, 16'h1234, -1, -1, 1'b0);
    checks++;
    if (cap_gain[4] !== 16'h4000) begin
      errors++;
      $display("FAIL write_mid_issue_cur: gain=%h, required 4000", cap_gain[4]);
    end
    run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (cap_gain[c] !== ((c == 4) ? 16'h1234 : 16'h4000)) begin
        errors++;
        $display("FAIL write_next_sample c%0d: gain=%h, required %h",
                 c, cap_gain[c], (c == 4) ? 16'h1234 : 16'h4000);
      end
    end
    write_gain(4'd2, 16'h4000);
  endtask

  task automatic test_bad_sel();
    write_gain(4'd7, 16'hFFFF);
    run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (cap_gain[c] !== 16'h4000) begin
        errors++;
        $display("FAIL bad_sel c%0d: gain=%h, required 4000", c, cap_gain[c]);
      end
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial: overrun=%b, required 0", overrun);
    end
    run_seq(-1, 4'd0, 16'h0000, 4, 4, 1'b0);
    checks++;
    if (cap_ov[4] !== 1'b0 || cap_ov[5] !== 1'b1 || cap_ov[12] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: c4=%b c5=%b c12=%b, required 0 1 1", cap_ov[4], cap_ov[5], cap_ov[12]);
    end
    checks++;
    if (cap_vld[9] !== 1'b1 || cap_busy[10] !== 1'b0 || cap_busy[11] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drop: vld9=%b busy10=%b busy11=%b, required 1 0 0",
               cap_vld[9], cap_busy[10], cap_busy[11]);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_after;
`ifdef EQ_GAIN_RAMP_EN
    exp_after = 16'h3E00;
`else
    exp_after = 16'h2000;
`endif
    for (int i = 0; i < 4; i++) write_gain(4'(i), 16'h2000);
    run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b1);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (cap_gain[c] !== 16'h4000) begin
        errors++;
        $display("FAIL bypass c%0d: gain=%h, required 4000", c, cap_gain[c]);
      end
    end
    run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b0);
    checks++;
    if (cap_gain[3] !== exp_after) begin
      errors++;
      $display("FAIL bypass_release: gain=%h, required %h", cap_gain[3], exp_after);
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic [15:0] exp_g;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("reset_mid_sequence");
    reset = 1'b0;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL strobe_after_reset: busy=%b, required 1", busy);
    end
    for (int c = 0; c < 12; c++) tick();
    for (int i = 0; i < 4; i++) write_gain(4'(i), 16'h4300);
    for (int s = 1; s <= 3; s++) begin
`ifdef EQ_GAIN_RAMP_EN
      exp_g = 16'h4000 + 16'(s) * 16'h0100;
`else
      exp_g = 16'h4300;
`endif
      run_seq(-1, 4'd0, 16'h0000, -1, -1, 1'b0);
      checks++;
      if (cap_gain[2] !== exp_g) begin
        errors++;
        $display("FAIL ramp_sample%0d: gain=%h, required %h", s, cap_gain[2], exp_g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_mid_issue();
    test_bad_sel();
    test_overrun();
    test_bypass();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
